credit_rr_port_arbiter: RTL and testbench

- Shares one downstream request port (for example an L2 or memory request bus) among NUM_REQUESTERS upstream sources.
- Selection is round-robin through the existing `rr_arbiter`.
- Packets are multi-beat, and the grant is held until the packet's last beat.
- Downstream flow control is credit based, and every output beat is registered.

---
 rtl/credit_rr_port_arbiter_pkg.sv | 22 ++
 rtl/credit_rr_port_arbiter_rr.sv | 47 ++++
 rtl/credit_rr_port_arbiter.sv | 122 ++++++++++++
 tb/tb_credit_rr_port_arbiter.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/credit_rr_port_arbiter_pkg.sv
// Shared types and helpers for the credit-based round-robin port arbiter.
package credit_rr_port_arbiter_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    localparam int unsigned DEF_NUM_REQUESTERS = 4;
    localparam int unsigned ID_WIDTH = $clog2(DEF_NUM_REQUESTERS);

    // OR-reduction of set-bit positions; exact for a one-hot input
    function automatic int unsigned oh_to_idx(input logic [31:0] oh);
        int unsigned idx;
        idx = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (oh[i]) idx = idx | i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/credit_rr_port_arbiter_rr.sv
// Round-robin arbiter; priority moves to one past the granted source on update_en.
module rr_arbiter
    import credit_rr_port_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQUESTERS = DEF_NUM_REQUESTERS
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQUESTERS-1:0] req_bitmap,
    input  logic                      update_en,
    output logic [NUM_REQUESTERS-1:0] grant_oh
);

    localparam int unsigned IW = $clog2(NUM_REQUESTERS);

    logic [IW-1:0] ptr_q, ptr_d;
    int unsigned   j;
    int unsigned   gidx;
    logic          found;

    always_comb begin
        grant_oh = '0;
        found    = 1'b0;
        j        = 0;
        for (int unsigned k = 0; k < NUM_REQUESTERS; k++) begin
            j = (32'(ptr_q) + k) % NUM_REQUESTERS;
            if (!found && req_bitmap[IW'(j)]) begin
                grant_oh[IW'(j)] = 1'b1;
                found            = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        gidx  = oh_to_idx(32'(grant_oh));
        if (update_en) begin
            ptr_d = (gidx == NUM_REQUESTERS - 1) ? '0 : IW'(gidx + 1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end

endmodule

// File: rtl/credit_rr_port_arbiter.sv
// Credit-gated, packet-locking round-robin arbiter for one shared request port.
module credit_rr_port_arbiter
    import credit_rr_port_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQUESTERS = DEF_NUM_REQUESTERS,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned NUM_CREDITS    = 4
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [NUM_REQUESTERS-1:0]            req_valid,
    input  logic [NUM_REQUESTERS-1:0]            req_last,
    input  logic [NUM_REQUESTERS*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQUESTERS-1:0]            req_ready,
    output logic                                 out_valid,
    output logic [DATA_WIDTH-1:0]                out_data,
    output logic [$clog2(NUM_REQUESTERS)-1:0]    out_id,
    output logic                                 out_last,
    input  logic                                 credit_return,
    output logic                                 credit_overflow
);

    localparam int unsigned N  = NUM_REQUESTERS;
    localparam int unsigned IW = $clog2(NUM_REQUESTERS);
    localparam int unsigned CW = $clog2(NUM_CREDITS + 1);

    arb_state_e      state_q, state_d;
    logic [N-1:0]    owner_q, owner_d;
    logic [N-1:0]    arb_req, grant_oh;
    logic [CW-1:0]   credit_q, credit_d;
    logic            ovf_q, ovf_d;
    logic            can_send, xfer, xfer_last;
    logic [DATA_WIDTH-1:0] sel_data;

    assign can_send  = (credit_q != '0);
    // While locked, presenting only the owner keeps the grant pinned to it
    assign arb_req   = (state_q == LOCKED) ? owner_q : req_valid;
    assign req_ready = grant_oh & {N{can_send & rst_n}};
    assign xfer      = |(req_valid & req_ready);
    assign xfer_last = |(req_valid & req_ready & req_last);

    rr_arbiter #(
        .NUM_REQUESTERS(N)
    ) u_rr (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_bitmap(arb_req),
        .update_en (xfer_last),
        .grant_oh  (grant_oh)
    );

    always_comb begin
        sel_data = '0;
        for (int unsigned i = 0; i < N; i++) begin
            sel_data = sel_data
                     | (req_data[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{req_ready[i]}});
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        unique case (state_q)
            IDLE: begin
                if (xfer && !xfer_last) begin
                    state_d = LOCKED;
                    owner_d = grant_oh;
                end
            end
            LOCKED: begin
                if (xfer_last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        credit_d = credit_q;
        ovf_d    = ovf_q;
        unique case ({xfer, credit_return})
            2'b10: credit_d = credit_q - CW'(1);
            2'b01: begin
                if (credit_q == CW'(NUM_CREDITS)) ovf_d    = 1'b1;
                else                              credit_d = credit_q + CW'(1);
            end
            default: credit_d = credit_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            credit_q <= CW'(NUM_CREDITS);
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            credit_q <= credit_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_id    <= '0;
            out_last  <= 1'b0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_id    <= IW'(oh_to_idx(32'(req_ready)));
            out_last  <= xfer_last;
        end else begin
            out_valid <= 1'b0;
        end
    end

    assign credit_overflow = ovf_q;

endmodule

// File: tb/tb_credit_rr_port_arbiter.sv
// Directed bench for credit_rr_port_arbiter: rotation, locking, credits, reset.
module tb_credit_rr_port_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_last;
    logic [127:0] req_data;
    logic [3:0]  req_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic [1:0]  out_id;
    logic        out_last;
    logic        credit_return;
    logic        credit_overflow;

    int total;
    int bad;

    credit_rr_port_arbiter #(
        .NUM_REQUESTERS(4),
        .DATA_WIDTH    (32),
        .NUM_CREDITS   (4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_last       (req_last),
        .req_data       (req_data),
        .req_ready      (req_ready),
        .out_valid      (out_valid),
        .out_data       (out_data),
        .out_id         (out_id),
        .out_last       (out_last),
        .credit_return  (credit_return),
        .credit_overflow(credit_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got,
                            input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int ids1 [5] = '{0, 1, 2, 3, 0};
    int ids3 [4] = '{3, 0, 1, 2};
    int ids5 [4] = '{2, 3, 0, 1};

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        req_valid = '0;
        req_last  = '0;
        credit_return = 1'b0;
        for (int i = 0; i < 4; i++) req_data[i*32 +: 32] = 32'hD0 + i;
        #3;
        check_eq("rst_ready", req_ready, 4'b0000);
        check_eq("rst_oval", out_valid, 1'b0);
        check_eq("rst_odata", out_data, 32'h0);
        check_eq("rst_oid", out_id, 2'd0);
        check_eq("rst_olast", out_last, 1'b0);
        check_eq("rst_ovf", credit_overflow, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;

        // round-robin with single-beat packets
        req_valid = 4'hF;
        req_last  = 4'hF;
        credit_return = 1'b1;
        #1;
        check_eq("rr_ready0", req_ready, 4'b0001);
        for (int k = 0; k < 5; k++) begin
            tick();
            check_eq("rr_oval", out_valid, 1'b1);
            check_eq("rr_oid", out_id, ids1[k]);
            check_eq("rr_odata", out_data, 32'hD0 + ids1[k]);
        end
        req_valid = '0;
        credit_return = 1'b0;

        // packet lock on source 1
        req_valid = 4'b0111;
        req_last  = 4'b0101;
        credit_return = 1'b1;
        #1;
        check_eq("lk_ready0", req_ready, 4'b0010);
        tick();
        check_eq("lk_id1", out_id, 2'd1);
        check_eq("lk_last1", out_last, 1'b0);
        check_eq("lk_ready1", req_ready, 4'b0010);
        tick();
        check_eq("lk_id2", out_id, 2'd1);
        check_eq("lk_ready2", req_ready, 4'b0010);
        req_last = 4'b0111;
        tick();
        check_eq("lk_id3", out_id, 2'd1);
        check_eq("lk_last3", out_last, 1'b1);
        check_eq("lk_ready3", req_ready, 4'b0100);
        tick();
        check_eq("lk_next_id", out_id, 2'd2);
        check_eq("lk_next_val", out_valid, 1'b1);
        req_valid = '0;
        credit_return = 1'b0;

        // credit exhaustion, then one returned credit
        req_valid = 4'hF;
        req_last  = 4'hF;
        #1;
        check_eq("cr_ready0", req_ready, 4'b1000);
        for (int k = 0; k < 4; k++) begin
            tick();
            check_eq("cr_oval", out_valid, 1'b1);
            check_eq("cr_oid", out_id, ids3[k]);
        end
        check_eq("cr_empty_ready", req_ready, 4'b0000);
        tick();
        check_eq("cr_stall_val", out_valid, 1'b0);
        credit_return = 1'b1;
        #1;
        check_eq("cr_ret_not_comb", req_ready, 4'b0000);
        tick();
        credit_return = 1'b0;
        check_eq("cr_ret_val", out_valid, 1'b0);
        check_eq("cr_ret_ready", req_ready, 4'b1000);
        tick();
        check_eq("cr_one_val", out_valid, 1'b1);
        check_eq("cr_one_id", out_id, 2'd3);
        check_eq("cr_one_ready", req_ready, 4'b0000);
        tick();
        check_eq("cr_after_val", out_valid, 1'b0);

        // send and return together at count 1
        credit_return = 1'b1;
        tick();
        check_eq("sr_ready0", req_ready, 4'b0001);
        tick();
        check_eq("sr_val0", out_valid, 1'b1);
        check_eq("sr_id0", out_id, 2'd0);
        check_eq("sr_ready1", req_ready, 4'b0010);
        tick();
        check_eq("sr_val1", out_valid, 1'b1);
        check_eq("sr_id1", out_id, 2'd1);
        check_eq("sr_ready2", req_ready, 4'b0100);
        req_valid = '0;

        // refill to full, then overflow
        tick();
        tick();
        tick();
        check_eq("ov_pre", credit_overflow, 1'b0);
        tick();
        check_eq("ov_set", credit_overflow, 1'b1);
        check_eq("ov_oval", out_valid, 1'b0);
        credit_return = 1'b0;
        req_valid = 4'hF;
        req_last  = 4'hF;
        #1;
        check_eq("ov_ready0", req_ready, 4'b0100);
        for (int k = 0; k < 4; k++) begin
            tick();
            check_eq("ov_oid", out_id, ids5[k]);
        end
        check_eq("ov_full4_ready", req_ready, 4'b0000);
        check_eq("ov_sticky", credit_overflow, 1'b1);
        tick();
        check_eq("ov_end_val", out_valid, 1'b0);

        // reset while locked
        req_valid = 4'b0010;
        req_last  = 4'b0000;
        credit_return = 1'b1;
        tick();
        check_eq("rl_ready", req_ready, 4'b0010);
        tick();
        check_eq("rl_id", out_id, 2'd1);
        check_eq("rl_last", out_last, 1'b0);
        credit_return = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("rl_rst_ready", req_ready, 4'b0000);
        check_eq("rl_rst_oval", out_valid, 1'b0);
        check_eq("rl_rst_odata", out_data, 32'h0);
        check_eq("rl_rst_oid", out_id, 2'd0);
        check_eq("rl_rst_olast", out_last, 1'b0);
        check_eq("rl_rst_ovf", credit_overflow, 1'b0);
        tick();
        rst_n = 1'b1;
        req_valid = 4'b1000;
        req_last  = 4'b1000;
        #1;
        check_eq("rl_new_ready", req_ready, 4'b1000);
        tick();
        check_eq("rl_new_val", out_valid, 1'b1);
        check_eq("rl_new_id", out_id, 2'd3);
        check_eq("rl_new_data", out_data, 32'hD3);
        req_valid = '0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
